// File: rtl/armleocpu_axi_arbiter2.sv
// Two-master to one-slave AXI4 arbiter: one whole transaction at a time, round-robin
// between masters, with all payloads passed through combinationally and unchanged.
module armleocpu_axi_arbiter2 #(
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ID_WIDTH-1:0]     M0_AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]   M0_AXI_AWADDR,
  input  logic [7:0]              M0_AXI_AWLEN,
  input  logic [2:0]              M0_AXI_AWSIZE,
  input  logic [1:0]              M0_AXI_AWBURST,
  input  logic                    M0_AXI_AWVALID,
  output logic                    M0_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   M0_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] M0_AXI_WSTRB,
  input  logic                    M0_AXI_WLAST,
  input  logic                    M0_AXI_WVALID,
  output logic                    M0_AXI_WREADY,
  output logic [ID_WIDTH-1:0]     M0_AXI_BID,
  output logic [1:0]              M0_AXI_BRESP,
  output logic                    M0_AXI_BVALID,
  input  logic                    M0_AXI_BREADY,
  input  logic [ID_WIDTH-1:0]     M0_AXI_ARID,
  input  logic [ADDR_WIDTH-1:0]   M0_AXI_ARADDR,
  input  logic [7:0]              M0_AXI_ARLEN,
  input  logic [2:0]              M0_AXI_ARSIZE,
  input  logic [1:0]              M0_AXI_ARBURST,
  input  logic                    M0_AXI_ARVALID,
  output logic                    M0_AXI_ARREADY,
  output logic [ID_WIDTH-1:0]     M0_AXI_RID,
  output logic [DATA_WIDTH-1:0]   M0_AXI_RDATA,
  output logic [1:0]              M0_AXI_RRESP,
  output logic                    M0_AXI_RLAST,
  output logic                    M0_AXI_RVALID,
  input  logic                    M0_AXI_RREADY,

  input  logic [ID_WIDTH-1:0]     M1_AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]   M1_AXI_AWADDR,
  input  logic [7:0]              M1_AXI_AWLEN,
  input  logic [2:0]              M1_AXI_AWSIZE,
  input  logic [1:0]              M1_AXI_AWBURST,
  input  logic                    M1_AXI_AWVALID,
  output logic                    M1_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   M1_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] M1_AXI_WSTRB,
  input  logic                    M1_AXI_WLAST,
  input  logic                    M1_AXI_WVALID,
  output logic                    M1_AXI_WREADY,
  output logic [ID_WIDTH-1:0]     M1_AXI_BID,
  output logic [1:0]              M1_AXI_BRESP,
  output logic                    M1_AXI_BVALID,
  input  logic                    M1_AXI_BREADY,
  input  logic [ID_WIDTH-1:0]     M1_AXI_ARID,
  input  logic [ADDR_WIDTH-1:0]   M1_AXI_ARADDR,
  input  logic [7:0]              M1_AXI_ARLEN,
  input  logic [2:0]              M1_AXI_ARSIZE,
  input  logic [1:0]              M1_AXI_ARBURST,
  input  logic                    M1_AXI_ARVALID,
  output logic                    M1_AXI_ARREADY,
  output logic [ID_WIDTH-1:0]     M1_AXI_RID,
  output logic [DATA_WIDTH-1:0]   M1_AXI_RDATA,
  output logic [1:0]              M1_AXI_RRESP,
  output logic                    M1_AXI_RLAST,
  output logic                    M1_AXI_RVALID,
  input  logic                    M1_AXI_RREADY,

  output logic [ID_WIDTH-1:0]     S_AXI_AWID,
  output logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  output logic [7:0]              S_AXI_AWLEN,
  output logic [2:0]              S_AXI_AWSIZE,
  output logic [1:0]              S_AXI_AWBURST,
  output logic                    S_AXI_AWVALID,
  input  logic                    S_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  output logic                    S_AXI_WLAST,
  output logic                    S_AXI_WVALID,
  input  logic                    S_AXI_WREADY,
  input  logic [ID_WIDTH-1:0]     S_AXI_BID,
  input  logic [1:0]              S_AXI_BRESP,
  input  logic                    S_AXI_BVALID,
  output logic                    S_AXI_BREADY,
  output logic [ID_WIDTH-1:0]     S_AXI_ARID,
  output logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  output logic [7:0]              S_AXI_ARLEN,
  output logic [2:0]              S_AXI_ARSIZE,
  output logic [1:0]              S_AXI_ARBURST,
  output logic                    S_AXI_ARVALID,
  input  logic                    S_AXI_ARREADY,
  input  logic [ID_WIDTH-1:0]     S_AXI_RID,
  input  logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  input  logic [1:0]              S_AXI_RRESP,
  input  logic                    S_AXI_RLAST,
  input  logic                    S_AXI_RVALID,
  output logic                    S_AXI_RREADY
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R
  } state_t;

  state_t state;
  logic   grant;
  logic   rr_last;

  logic req0, req1, arb_grant, arb_write;

  assign req0      = M0_AXI_AWVALID | M0_AXI_ARVALID;
  assign req1      = M1_AXI_AWVALID | M1_AXI_ARVALID;
  // On a tie the master that was not served last wins.
  assign arb_grant = (req0 & req1) ? ~rr_last : req1;
  assign arb_write = arb_grant ? M1_AXI_AWVALID : M0_AXI_AWVALID;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant   <= 1'b0;
      rr_last <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: if (req0 | req1) begin
          grant <= arb_grant;
          state <= arb_write ? ST_AW : ST_AR;
        end
        ST_AW: if (S_AXI_AWVALID & S_AXI_AWREADY) state <= ST_W;
        ST_W:  if (S_AXI_WVALID & S_AXI_WREADY & S_AXI_WLAST) state <= ST_B;
        ST_B:  if (S_AXI_BVALID & S_AXI_BREADY) begin
          state   <= ST_IDLE;
          rr_last <= grant;
        end
        ST_AR: if (S_AXI_ARVALID & S_AXI_ARREADY) state <= ST_R;
        ST_R:  if (S_AXI_RVALID & S_AXI_RREADY & S_AXI_RLAST) begin
          state   <= ST_IDLE;
          rr_last <= grant;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a zero default first so no path through the case
  // leaves a value held, which would infer a latch.
  always_comb begin
    M0_AXI_AWREADY = 1'b0; M0_AXI_WREADY = 1'b0; M0_AXI_ARREADY = 1'b0;
    M0_AXI_BID = '0; M0_AXI_BRESP = '0; M0_AXI_BVALID = 1'b0;
    M0_AXI_RID = '0; M0_AXI_RDATA = '0; M0_AXI_RRESP = '0;
    M0_AXI_RLAST = 1'b0; M0_AXI_RVALID = 1'b0;
    M1_AXI_AWREADY = 1'b0; M1_AXI_WREADY = 1'b0; M1_AXI_ARREADY = 1'b0;
    M1_AXI_BID = '0; M1_AXI_BRESP = '0; M1_AXI_BVALID = 1'b0;
    M1_AXI_RID = '0; M1_AXI_RDATA = '0; M1_AXI_RRESP = '0;
    M1_AXI_RLAST = 1'b0; M1_AXI_RVALID = 1'b0;
    S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0;
    S_AXI_AWSIZE = '0; S_AXI_AWBURST = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0;
    S_AXI_ARSIZE = '0; S_AXI_ARBURST = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;

    unique case (state)
      ST_AW: begin
        S_AXI_AWID    = grant ? M1_AXI_AWID    : M0_AXI_AWID;
        S_AXI_AWADDR  = grant ? M1_AXI_AWADDR  : M0_AXI_AWADDR;
        S_AXI_AWLEN   = grant ? M1_AXI_AWLEN   : M0_AXI_AWLEN;
        S_AXI_AWSIZE  = grant ? M1_AXI_AWSIZE  : M0_AXI_AWSIZE;
        S_AXI_AWBURST = grant ? M1_AXI_AWBURST : M0_AXI_AWBURST;
        S_AXI_AWVALID = grant ? M1_AXI_AWVALID : M0_AXI_AWVALID;
        if (grant) M1_AXI_AWREADY = S_AXI_AWREADY;
        else       M0_AXI_AWREADY = S_AXI_AWREADY;
      end
      ST_W: begin
        S_AXI_WDATA  = grant ? M1_AXI_WDATA  : M0_AXI_WDATA;
        S_AXI_WSTRB  = grant ? M1_AXI_WSTRB  : M0_AXI_WSTRB;
        S_AXI_WLAST  = grant ? M1_AXI_WLAST  : M0_AXI_WLAST;
        S_AXI_WVALID = grant ? M1_AXI_WVALID : M0_AXI_WVALID;
        if (grant) M1_AXI_WREADY = S_AXI_WREADY;
        else       M0_AXI_WREADY = S_AXI_WREADY;
      end
      ST_B: begin
        S_AXI_BREADY = grant ? M1_AXI_BREADY : M0_AXI_BREADY;
        if (grant) begin
          M1_AXI_BID = S_AXI_BID; M1_AXI_BRESP = S_AXI_BRESP; M1_AXI_BVALID = S_AXI_BVALID;
        end else begin
          M0_AXI_BID = S_AXI_BID; M0_AXI_BRESP = S_AXI_BRESP; M0_AXI_BVALID = S_AXI_BVALID;
        end
      end
      ST_AR: begin
        S_AXI_ARID    = grant ? M1_AXI_ARID    : M0_AXI_ARID;
        S_AXI_ARADDR  = grant ? M1_AXI_ARADDR  : M0_AXI_ARADDR;
        S_AXI_ARLEN   = grant ? M1_AXI_ARLEN   : M0_AXI_ARLEN;
        S_AXI_ARSIZE  = grant ? M1_AXI_ARSIZE  : M0_AXI_ARSIZE;
        S_AXI_ARBURST = grant ? M1_AXI_ARBURST : M0_AXI_ARBURST;
        S_AXI_ARVALID = grant ? M1_AXI_ARVALID : M0_AXI_ARVALID;
        if (grant) M1_AXI_ARREADY = S_AXI_ARREADY;
        else       M0_AXI_ARREADY = S_AXI_ARREADY;
      end
      ST_R: begin
        S_AXI_RREADY = grant ? M1_AXI_RREADY : M0_AXI_RREADY;
        if (grant) begin
          M1_AXI_RID = S_AXI_RID; M1_AXI_RDATA = S_AXI_RDATA; M1_AXI_RRESP = S_AXI_RRESP;
          M1_AXI_RLAST = S_AXI_RLAST; M1_AXI_RVALID = S_AXI_RVALID;
        end else begin
          M0_AXI_RID = S_AXI_RID; M0_AXI_RDATA = S_AXI_RDATA; M0_AXI_RRESP = S_AXI_RRESP;
          M0_AXI_RLAST = S_AXI_RLAST; M0_AXI_RVALID = S_AXI_RVALID;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_armleocpu_axi_arbiter2.sv
// Directed bench for armleocpu_axi_arbiter2: masters queue expected transactions in
// grant order, and a bench-side slave pops and checks each one as it appears.
module tb_armleocpu_axi_arbiter2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        m;
    logic        wr;
    logic [7:0]  id;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [31:0] data;
  } txn_t;

  txn_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  m_awid[2];   logic [15:0] m_awaddr[2]; logic [7:0] m_awlen[2];
  logic [2:0]  m_awsize[2]; logic [1:0]  m_awburst[2]; logic m_awvalid[2], m_awready[2];
  logic [31:0] m_wdata[2];  logic [3:0]  m_wstrb[2];
  logic        m_wlast[2], m_wvalid[2], m_wready[2];
  logic [7:0]  m_bid[2];    logic [1:0]  m_bresp[2];  logic m_bvalid[2], m_bready[2];
  logic [7:0]  m_arid[2];   logic [15:0] m_araddr[2]; logic [7:0] m_arlen[2];
  logic [2:0]  m_arsize[2]; logic [1:0]  m_arburst[2]; logic m_arvalid[2], m_arready[2];
  logic [7:0]  m_rid[2];    logic [31:0] m_rdata[2];  logic [1:0] m_rresp[2];
  logic        m_rlast[2], m_rvalid[2], m_rready[2];

  logic [7:0]  s_awid;   logic [15:0] s_awaddr; logic [7:0] s_awlen;
  logic [2:0]  s_awsize; logic [1:0]  s_awburst; logic s_awvalid, s_awready;
  logic [31:0] s_wdata;  logic [3:0]  s_wstrb; logic s_wlast, s_wvalid, s_wready;
  logic [7:0]  s_bid;    logic [1:0]  s_bresp; logic s_bvalid, s_bready;
  logic [7:0]  s_arid;   logic [15:0] s_araddr; logic [7:0] s_arlen;
  logic [2:0]  s_arsize; logic [1:0]  s_arburst; logic s_arvalid, s_arready;
  logic [7:0]  s_rid;    logic [31:0] s_rdata; logic [1:0] s_rresp;
  logic        s_rlast, s_rvalid, s_rready;

  logic [1:0] m_any;
  logic       s_any, any_out;

  assign m_any[0] = m_awready[0] | m_wready[0] | m_arready[0] | m_bvalid[0] | (|m_bid[0]) |
                    (|m_bresp[0]) | (|m_rid[0]) | (|m_rdata[0]) | (|m_rresp[0]) |
                    m_rlast[0] | m_rvalid[0];
  assign m_any[1] = m_awready[1] | m_wready[1] | m_arready[1] | m_bvalid[1] | (|m_bid[1]) |
                    (|m_bresp[1]) | (|m_rid[1]) | (|m_rdata[1]) | (|m_rresp[1]) |
                    m_rlast[1] | m_rvalid[1];
  assign s_any = s_awvalid | (|s_awid) | (|s_awaddr) | (|s_awlen) | (|s_awsize) | (|s_awburst) |
                 s_wvalid | (|s_wdata) | (|s_wstrb) | s_wlast | s_bready |
                 s_arvalid | (|s_arid) | (|s_araddr) | (|s_arlen) | (|s_arsize) | (|s_arburst) |
                 s_rready;
  assign any_out = m_any[0] | m_any[1] | s_any;

  armleocpu_axi_arbiter2 #(.ADDR_WIDTH(16), .ID_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .M0_AXI_AWID(m_awid[0]), .M0_AXI_AWADDR(m_awaddr[0]), .M0_AXI_AWLEN(m_awlen[0]),
    .M0_AXI_AWSIZE(m_awsize[0]), .M0_AXI_AWBURST(m_awburst[0]),
    .M0_AXI_AWVALID(m_awvalid[0]), .M0_AXI_AWREADY(m_awready[0]),
    .M0_AXI_WDATA(m_wdata[0]), .M0_AXI_WSTRB(m_wstrb[0]), .M0_AXI_WLAST(m_wlast[0]),
    .M0_AXI_WVALID(m_wvalid[0]), .M0_AXI_WREADY(m_wready[0]),
    .M0_AXI_BID(m_bid[0]), .M0_AXI_BRESP(m_bresp[0]), .M0_AXI_BVALID(m_bvalid[0]),
    .M0_AXI_BREADY(m_bready[0]),
    .M0_AXI_ARID(m_arid[0]), .M0_AXI_ARADDR(m_araddr[0]), .M0_AXI_ARLEN(m_arlen[0]),
    .M0_AXI_ARSIZE(m_arsize[0]), .M0_AXI_ARBURST(m_arburst[0]),
    .M0_AXI_ARVALID(m_arvalid[0]), .M0_AXI_ARREADY(m_arready[0]),
    .M0_AXI_RID(m_rid[0]), .M0_AXI_RDATA(m_rdata[0]), .M0_AXI_RRESP(m_rresp[0]),
    .M0_AXI_RLAST(m_rlast[0]), .M0_AXI_RVALID(m_rvalid[0]), .M0_AXI_RREADY(m_rready[0]),
    .M1_AXI_AWID(m_awid[1]), .M1_AXI_AWADDR(m_awaddr[1]), .M1_AXI_AWLEN(m_awlen[1]),
    .M1_AXI_AWSIZE(m_awsize[1]), .M1_AXI_AWBURST(m_awburst[1]),
    .M1_AXI_AWVALID(m_awvalid[1]), .M1_AXI_AWREADY(m_awready[1]),
    .M1_AXI_WDATA(m_wdata[1]), .M1_AXI_WSTRB(m_wstrb[1]), .M1_AXI_WLAST(m_wlast[1]),
    .M1_AXI_WVALID(m_wvalid[1]), .M1_AXI_WREADY(m_wready[1]),
    .M1_AXI_BID(m_bid[1]), .M1_AXI_BRESP(m_bresp[1]), .M1_AXI_BVALID(m_bvalid[1]),
    .M1_AXI_BREADY(m_bready[1]),
    .M1_AXI_ARID(m_arid[1]), .M1_AXI_ARADDR(m_araddr[1]), .M1_AXI_ARLEN(m_arlen[1]),
    .M1_AXI_ARSIZE(m_arsize[1]), .M1_AXI_ARBURST(m_arburst[1]),
    .M1_AXI_ARVALID(m_arvalid[1]), .M1_AXI_ARREADY(m_arready[1]),
    .M1_AXI_RID(m_rid[1]), .M1_AXI_RDATA(m_rdata[1]), .M1_AXI_RRESP(m_rresp[1]),
    .M1_AXI_RLAST(m_rlast[1]), .M1_AXI_RVALID(m_rvalid[1]), .M1_AXI_RREADY(m_rready[1]),
    .S_AXI_AWID(s_awid), .S_AXI_AWADDR(s_awaddr), .S_AXI_AWLEN(s_awlen),
    .S_AXI_AWSIZE(s_awsize), .S_AXI_AWBURST(s_awburst),
    .S_AXI_AWVALID(s_awvalid), .S_AXI_AWREADY(s_awready),
    .S_AXI_WDATA(s_wdata), .S_AXI_WSTRB(s_wstrb), .S_AXI_WLAST(s_wlast),
    .S_AXI_WVALID(s_wvalid), .S_AXI_WREADY(s_wready),
    .S_AXI_BID(s_bid), .S_AXI_BRESP(s_bresp), .S_AXI_BVALID(s_bvalid), .S_AXI_BREADY(s_bready),
    .S_AXI_ARID(s_arid), .S_AXI_ARADDR(s_araddr), .S_AXI_ARLEN(s_arlen),
    .S_AXI_ARSIZE(s_arsize), .S_AXI_ARBURST(s_arburst),
    .S_AXI_ARVALID(s_arvalid), .S_AXI_ARREADY(s_arready),
    .S_AXI_RID(s_rid), .S_AXI_RDATA(s_rdata), .S_AXI_RRESP(s_rresp),
    .S_AXI_RLAST(s_rlast), .S_AXI_RVALID(s_rvalid), .S_AXI_RREADY(s_rready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_write(input int m, input logic [7:0] id, input logic [15:0] addr,
                         input logic [31:0] data);
    txn_t t;
    m_awid[m] = id; m_awaddr[m] = addr; m_awlen[m] = 8'd0;
    m_awsize[m] = 3'd2; m_awburst[m] = 2'd1; m_awvalid[m] = 1'b1;
    m_wdata[m] = data; m_wstrb[m] = 4'hf; m_wlast[m] = 1'b1; m_wvalid[m] = 1'b1;
    m_bready[m] = 1'b1;
    t = '{m: 1'(m), wr: 1'b1, id: id, addr: addr, len: 8'd0, data: data};
    sb.push_back(t);
  endtask

  task automatic m_read(input int m, input logic [7:0] id, input logic [15:0] addr,
                        input logic [7:0] len);
    txn_t t;
    m_arid[m] = id; m_araddr[m] = addr; m_arlen[m] = len;
    m_arsize[m] = 3'd2; m_arburst[m] = 2'd1; m_arvalid[m] = 1'b1;
    m_rready[m] = 1'b1;
    t = '{m: 1'(m), wr: 1'b0, id: id, addr: addr, len: len, data: 32'd0};
    sb.push_back(t);
  endtask

  // Slave side: wait for the next address, match it against the oldest expected
  // transaction and complete it; exp_wait is the number of edges until address valid.
  task automatic serve(input int exp_wait, input bit bp);
    txn_t        t;
    int          w;
    logic [31:0] rd;
    logic [1:0]  hot;
    w = 0;
    #1;
    while (!(s_awvalid || s_arvalid) && w < 40) begin
      tick();
      w++;
    end
    check("slave_addr_valid", 64'(s_awvalid | s_arvalid), 64'd1);
    if (!(s_awvalid | s_arvalid)) return;
    check("arb_latency", 64'(w), 64'(exp_wait));
    t   = sb.pop_front();
    hot = t.m ? 2'b10 : 2'b01;
    check("channel_kind", 64'({s_awvalid, s_arvalid}), 64'({t.wr, ~t.wr}));
    if (t.wr) begin
      check("aw_payload", 64'({s_awid, s_awaddr, s_awlen, s_awsize, s_awburst}),
            64'({t.id, t.addr, t.len, 3'd2, 2'd1}));
      s_awready = 1'b1;
      #1;
      check("awready_route", 64'({m_awready[1], m_awready[0]}), 64'(hot));
      tick();
      s_awready = 1'b0;
      m_awvalid[t.m] = 1'b0;
      #1;
      check("w_payload", 64'({s_wvalid, s_wdata, s_wstrb, s_wlast}),
            64'({1'b1, t.data, 4'hf, 1'b1}));
      s_wready = 1'b1;
      #1;
      check("wready_route", 64'({m_wready[1], m_wready[0]}), 64'(hot));
      check("other_quiet_w", 64'(m_any[~t.m]), 64'd0);
      tick();
      s_wready = 1'b0;
      m_wvalid[t.m] = 1'b0;
      s_bvalid = 1'b1; s_bid = t.id; s_bresp = t.id[1:0];
      #1;
      check("b_route", 64'({m_bvalid[1], m_bvalid[0]}), 64'(hot));
      check("b_payload", 64'({m_bid[t.m], m_bresp[t.m], s_bready}),
            64'({t.id, t.id[1:0], 1'b1}));
      tick();
      s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;
    end else begin
      check("ar_payload", 64'({s_arid, s_araddr, s_arlen, s_arsize, s_arburst}),
            64'({t.id, t.addr, t.len, 3'd2, 2'd1}));
      s_arready = 1'b1;
      #1;
      check("arready_route", 64'({m_arready[1], m_arready[0]}), 64'(hot));
      tick();
      s_arready = 1'b0;
      m_arvalid[t.m] = 1'b0;
      for (int b = 0; b <= int'(t.len); b++) begin
        rd = {t.addr, 8'h5a, 8'(b)};
        s_rvalid = 1'b1; s_rid = t.id; s_rdata = rd; s_rresp = 2'b00;
        s_rlast = (b == int'(t.len));
        if (bp) begin
          m_rready[t.m] = 1'b0;
          #1;
          check("r_stall", 64'({m_rvalid[t.m], s_rready}), 64'(2'b10));
          tick();
          m_rready[t.m] = 1'b1;
        end
        #1;
        check("r_route", 64'({m_rvalid[1], m_rvalid[0]}), 64'(hot));
        check("r_payload", 64'({m_rid[t.m], m_rdata[t.m], m_rlast[t.m], s_rready}),
              64'({t.id, rd, b == int'(t.len), 1'b1}));
        check("other_quiet_r", 64'(m_any[~t.m]), 64'd0);
        tick();
      end
      s_rvalid = 1'b0; s_rid = '0; s_rdata = '0; s_rlast = 1'b0;
    end
    #1;
    check("idle_after_txn", 64'({s_awvalid, s_arvalid, s_wvalid, s_rready, s_bready}), 64'd0);
  endtask

  initial begin
    txn_t dropped;
    for (int i = 0; i < 2; i++) begin
      m_awid[i] = '0; m_awaddr[i] = '0; m_awlen[i] = '0; m_awsize[i] = '0;
      m_awburst[i] = '0; m_awvalid[i] = 1'b0;
      m_wdata[i] = '0; m_wstrb[i] = '0; m_wlast[i] = 1'b0; m_wvalid[i] = 1'b0;
      m_bready[i] = 1'b0;
      m_arid[i] = '0; m_araddr[i] = '0; m_arlen[i] = '0; m_arsize[i] = '0;
      m_arburst[i] = '0; m_arvalid[i] = 1'b0; m_rready[i] = 1'b0;
    end
    s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
    s_bid = '0; s_bresp = '0; s_bvalid = 1'b0;
    s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;

    // Reset with live requests: everything must stay at zero.
    #1 rst = 1'b1;
    m_awvalid[0] = 1'b1; m_arvalid[1] = 1'b1; m_wvalid[1] = 1'b1; m_bready[0] = 1'b1;
    #2;
    check("reset_outputs_zero", 64'(any_out), 64'd0);
    repeat (3) tick();
    check("reset_held_zero", 64'(any_out), 64'd0);
    m_awvalid[0] = 1'b0; m_arvalid[1] = 1'b0; m_wvalid[1] = 1'b0; m_bready[0] = 1'b0;
    rst = 1'b0;

    // Single M0 write.
    m_write(0, 8'h05, 16'h4000, 32'h1234_5678);
    serve(1, 1'b0);

    // Simultaneous writes right after reset: M0 first, M1 two cycles after M0's B.
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    m_write(0, 8'h11, 16'h4004, 32'hA5A5_0001);
    m_write(1, 8'h21, 16'h4100, 32'h5A5A_0002);
    serve(1, 1'b0);
    serve(1, 1'b0);

    // Both masters streaming reads: grants alternate M0, M1, ... over 8 transactions.
    m_read(0, 8'h30, 16'h0100, 8'd1);
    m_read(1, 8'h31, 16'h0200, 8'd0);
    for (int i = 0; i < 8; i++) begin
      serve(1, 1'b0);
      if (i < 6) m_read(i % 2, 8'(8'h40 + i), 16'(16'h1000 + 16 * i), 8'(i % 2));
    end

    // M1 presents AW and AR together: write is served first, read afterwards.
    m_write(1, 8'h55, 16'h4200, 32'hCAFE_F00D);
    m_read(1, 8'h56, 16'h4204, 8'd0);
    serve(1, 1'b0);
    serve(1, 1'b0);

    // M0 4-beat read with master RREADY stalling every other cycle.
    m_read(0, 8'h60, 16'h4300, 8'd3);
    serve(1, 1'b1);

    // Reset during M1's W phase, then both request: M0 must win.
    m_write(1, 8'h70, 16'h4400, 32'hDEAD_BEEF);
    dropped = sb.pop_front();
    tick();
    check("abort_aw_valid", 64'({s_awvalid, s_awid}), 64'({1'b1, dropped.id}));
    s_awready = 1'b1;
    tick();
    s_awready = 1'b0;
    m_awvalid[1] = 1'b0;
    #1;
    check("abort_in_w", 64'({s_wvalid, s_wdata}), 64'({1'b1, dropped.data}));
    rst = 1'b1;
    #1;
    check("abort_reset_zero", 64'(any_out), 64'd0);
    m_write(0, 8'h80, 16'h4500, 32'h0BAD_F00D);
    m_write(1, 8'h81, 16'h4600, 32'h1357_9BDF);
    tick();
    rst = 1'b0;
    serve(1, 1'b0);
    serve(1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
